// File: rtl/t05_bitstream_arbiter.sv
// t05_bitstream_arbiter
// Two serial bit producers (HDR, CODE) share one byte-wide SRAM write path.
// One source is granted at a time. Accepted bits are packed MSB-first into bytes,
// and the bytes are buffered in a small FIFO. The FIFO drains to memory over a
// req/ack handshake. A flush command pads the final partial byte with zeros and
// drains everything, then pulses done.
// Build option: define T05_RR_ARB_EN to use round-robin tie breaking between
// the two sources. Without it, HDR has fixed priority.

module t05_bitstream_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hdr_valid,
    input  logic              hdr_bit,
    input  logic              hdr_last,
    output logic              hdr_ready,
    input  logic              code_valid,
    input  logic              code_bit,
    input  logic              code_last,
    output logic              code_ready,
    input  logic              flush,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  total_bits
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT_HDR,
        S_GNT_CODE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               flush_pend_q, flush_pend_d;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic [7:0]         push_data;

    logic               room;
    logic               tie_to_hdr;
    logic               acc_en, acc_bit;

`ifdef T05_RR_ARB_EN
    // 1 = CODE was granted last; starts at CODE so HDR wins the first tie
    logic               last_gnt_q, last_gnt_d;
`endif

    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // The completing 8th bit may only be taken when the FIFO can hold the byte
    assign room = !((bit_cnt_q == 3'd7) && fifo_full);

`ifdef T05_RR_ARB_EN
    assign tie_to_hdr = last_gnt_q;
`else
    assign tie_to_hdr = 1'b1;
`endif

    // Next-state, grant, bit packing and flush sequencing
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        total_d      = total_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_data    = 8'h00;
        hdr_ready    = 1'b0;
        code_ready   = 1'b0;
        done         = 1'b0;
        acc_en       = 1'b0;
        acc_bit      = 1'b0;
`ifdef T05_RR_ARB_EN
        last_gnt_d   = last_gnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d   = '0;
                    bit_cnt_d = 3'd0;
                end
                if (flush || flush_pend_q) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                end else if (hdr_valid && (!code_valid || tie_to_hdr)) begin
                    state_d = S_GNT_HDR;
`ifdef T05_RR_ARB_EN
                    last_gnt_d = 1'b0;
`endif
                end else if (code_valid) begin
                    state_d = S_GNT_CODE;
`ifdef T05_RR_ARB_EN
                    last_gnt_d = 1'b1;
`endif
                end
            end
            S_GNT_HDR: begin
                hdr_ready = room;
                if (flush) flush_pend_d = 1'b1;
                if (hdr_valid && room) begin
                    acc_en  = 1'b1;
                    acc_bit = hdr_bit;
                    if (hdr_last) state_d = S_IDLE;
                end
            end
            S_GNT_CODE: begin
                code_ready = room;
                if (flush) flush_pend_d = 1'b1;
                if (code_valid && room) begin
                    acc_en  = 1'b1;
                    acc_bit = code_bit;
                    if (code_last) state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (bit_cnt_q == 3'd0) begin
                    state_d = S_DRAIN;
                end else if (!fifo_full) begin
                    // Left-justify the partial byte; the vacated low bits are zero padding
                    push      = 1'b1;
                    push_data = shift_q << (4'd8 - {1'b0, bit_cnt_q});
                    bit_cnt_d = 3'd0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_en) begin
            shift_d   = {shift_q[6:0], acc_bit};
            bit_cnt_d = bit_cnt_q + 3'd1;
            total_d   = total_q + CNT_W'(1);
            if (bit_cnt_q == 3'd7) begin
                push      = 1'b1;
                push_data = {shift_q[6:0], acc_bit};
            end
        end
    end

    // Memory-side pop and write address, independent of the grant state
    always_comb begin
        pop    = wr_ack && !fifo_empty;
        addr_d = addr_q;
        if (pop) addr_d = addr_q + ADDR_W'(1);
        if ((state_q == S_IDLE) && start) addr_d = base_addr;
    end

    // Control state registers
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            total_q      <= '0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            total_q      <= total_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef T05_RR_ARB_EN
    // Remember which source was granted last for round-robin tie breaking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_gnt_q <= 1'b1;
        else     last_gnt_q <= last_gnt_d;
    end
`endif

    // FIFO pointers and occupancy; push and pop on one edge leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage
    // NOTE: the byte array is not reset; pointers and count define validity, and the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    assign wr_req     = !fifo_empty;
    assign wr_addr    = addr_q;
    assign wr_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign total_bits = total_q;

endmodule

// File: tb/tb_t05_bitstream_arbiter.sv
// tb_t05_bitstream_arbiter
// Directed stimulus for t05_bitstream_arbiter. A bit-level scoreboard derives
// the expected byte stream, the write addresses and the bit count from the
// accepted handshakes. Literal checks pin specific bytes and events.
// The tie-break expectations follow T05_RR_ARB_EN in the same way the design does.

module tb_t05_bitstream_arbiter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        hdr_valid, hdr_bit, hdr_last, hdr_ready;
    logic        code_valid, code_bit, code_last, code_ready;
    logic        flush;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        busy, done;
    logic [23:0] total_bits;

    int checks = 0;
    int errors = 0;

    // Scoreboard state
    logic [7:0]  exp_q [$];
    logic [7:0]  m_part;
    int          m_n;
    logic [23:0] m_total;
    logic [31:0] m_addr;
    bit          m_flush;
    int          done_cnt = 0;
    bit          prev_hold;
    logic [31:0] prev_addr;
    logic [7:0]  prev_data;
    logic [7:0]  log_data [$];
    logic [31:0] log_addr [$];

    t05_bitstream_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .hdr_valid  (hdr_valid),
        .hdr_bit    (hdr_bit),
        .hdr_last   (hdr_last),
        .hdr_ready  (hdr_ready),
        .code_valid (code_valid),
        .code_bit   (code_bit),
        .code_last  (code_last),
        .code_ready (code_ready),
        .flush      (flush),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .done       (done),
        .total_bits (total_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one accepted bit, MSB-first into the byte under construction
    task model_bit(input logic b);
        m_part = {m_part[6:0], b};
        m_n++;
        m_total = m_total + 24'd1;
        if (m_n == 8) begin
            exp_q.push_back(m_part);
            m_part = 8'h00;
            m_n = 0;
        end
    endtask

    // Scoreboard: one completed memory write
    task model_write();
        logic [7:0] e;
        bit ok;
        ok = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else if (m_flush && m_n > 0) begin
            e = m_part << (8 - m_n);
            m_part = 8'h00;
            m_n = 0;
        end else begin
            ok = 1'b0;
            e = 8'h00;
        end
        check("write_expected", ok, 1);
        check("wr_data", wr_data, e);
        check("wr_addr", wr_addr, m_addr);
        log_data.push_back(wr_data);
        log_addr.push_back(wr_addr);
        m_addr = m_addr + 32'd1;
    endtask

    // Compare process: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            check("rst_wr_req", wr_req, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_hdr_ready", hdr_ready, 0);
            check("rst_code_ready", code_ready, 0);
            check("rst_total_bits", total_bits, 0);
            exp_q.delete();
            m_part = 8'h00;
            m_n = 0;
            m_total = 24'd0;
            m_addr = 32'd0;
            m_flush = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("total_bits", total_bits, m_total);
            check("ready_exclusive", hdr_ready & code_ready, 0);
            if (prev_hold) begin
                check("hold_wr_req", wr_req, 1);
                check("hold_wr_addr", wr_addr, prev_addr);
                check("hold_wr_data", wr_data, prev_data);
            end
            if (start) begin
                m_addr = base_addr;
                m_total = 24'd0;
                m_part = 8'h00;
                m_n = 0;
            end
            if (hdr_valid && hdr_ready) model_bit(hdr_bit);
            if (code_valid && code_ready) model_bit(code_bit);
            if (wr_req && wr_ack) model_write();
            if (done) begin
                done_cnt++;
                check("done_after_flush", m_flush, 1);
                check("done_all_written", exp_q.size() + m_n, 0);
                m_flush = 1'b0;
            end
            if (flush) m_flush = 1'b1;
            prev_hold = wr_req && !wr_ack;
            prev_addr = wr_addr;
            prev_data = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input bit is_code, input logic v, input logic b, input logic l);
        if (is_code) begin
            code_valid = v; code_bit = b; code_last = l;
        end else begin
            hdr_valid = v; hdr_bit = b; hdr_last = l;
        end
    endtask

    // Send n bits MSB-first from one source; reports whether the other source saw ready
    task automatic send(input bit is_code, input logic [63:0] bits, input int n,
                        input bit last_on_end, output bit other_rdy);
        other_rdy = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            bit acc;
            int guard;
            acc = 1'b0;
            guard = 0;
            drive_src(is_code, 1'b1, bits[i], last_on_end && (i == 0));
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = is_code ? code_ready : hdr_ready;
                if (is_code ? hdr_ready : code_ready) other_rdy = 1'b1;
                tick();
                guard++;
            end
            if (!acc) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        drive_src(is_code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start(input logic [31:0] a);
        base_addr = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        check(name, seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit o;
        int dc;
        int sz;

        rst = 1'b1; start = 1'b0; base_addr = 32'h0;
        hdr_valid = 1'b0; hdr_bit = 1'b0; hdr_last = 1'b0;
        code_valid = 1'b0; code_bit = 1'b0; code_last = 1'b0;
        flush = 1'b0; wr_ack = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // HDR 9'h141 from base 0x100: first byte 0xA0, one bit left over
        do_start(32'h100);
        drive_src(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("idle_no_accept_hdr", hdr_ready, 0);
        check("idle_no_accept_code", code_ready, 0);
        tick();
        send(1'b0, 64'h141, 9, 1'b1, o);
        check("t1_code_not_ready", o, 0);
        repeat (3) tick();
        check("t1_nbytes", log_data.size(), 1);
        check("t1_byte0", log_data[0], 8'hA0);
        check("t1_addr0", log_addr[0], 32'h100);
        check("t1_total", total_bits, 9);

        // CODE 1010101 completes 0xD5 with no padding, then flush
        send(1'b1, 64'h55, 7, 1'b1, o);
        pulse_flush();
        wait_done("t1_done_seen");
        check("t1b_nbytes", log_data.size(), 2);
        check("t1b_byte1", log_data[1], 8'hD5);
        check("t1b_addr1", log_addr[1], 32'h101);
        check("t1b_total", total_bits, 16);
        check("t1b_done_cnt", done_cnt, 1);

        // Tie in IDLE: HDR wins in both modes, CODE stays blocked for the whole burst
        drive_src(1'b1, 1'b1, 1'b1, 1'b1);
        send(1'b0, 64'hC, 4, 1'b1, o);
        check("tie1_code_blocked", o, 0);
        send(1'b1, 64'h1, 1, 1'b1, o);
        send(1'b0, 64'h3, 3, 1'b1, o);
        // Second tie: fixed priority keeps HDR; round-robin picks CODE
`ifdef T05_RR_ARB_EN
        drive_src(1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b1, 64'h9, 4, 1'b1, o);
        check("tie2_hdr_blocked", o, 0);
        send(1'b0, 64'h1, 1, 1'b1, o);
`else
        drive_src(1'b1, 1'b1, 1'b1, 1'b1);
        send(1'b0, 64'h9, 4, 1'b1, o);
        check("tie2_code_blocked", o, 0);
        send(1'b1, 64'h1, 1, 1'b1, o);
`endif
        pulse_flush();
        wait_done("tie_done_seen");
        sz = log_data.size();
        check("tie_byte_cb", log_data[sz-2], 8'hCB);
        check("tie_byte_98_padded", log_data[sz-1], 8'h98);

        // Back-pressure: FIFO full and bit_cnt==7 holds off the 8th bit until one ack
        wr_ack = 1'b0;
        send(1'b0, 64'h12_3456_789B >> 1, 39, 1'b0, o);
        drive_src(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", hdr_ready, 0);
            check("bp_wr_req", wr_req, 1);
            tick();
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        send(1'b0, 64'h1, 1, 1'b1, o);
        wr_ack = 1'b1;
        pulse_flush();
        wait_done("bp_done_seen");
        sz = log_data.size();
        check("bp_first_byte", log_data[sz-5], 8'h12);
        check("bp_last_byte", log_data[sz-1], 8'h9B);

        // 3 bits 101 then flush: padded 0xA0, one done, idle afterwards
        dc = done_cnt;
        send(1'b0, 64'h5, 3, 1'b1, o);
        pulse_flush();
        wait_done("pad_done_seen");
        check("pad_byte", log_data[log_data.size()-1], 8'hA0);
        repeat (5) tick();
        check("pad_done_once", done_cnt, dc + 1);
        check("pad_busy_low", busy, 0);

        // Flush mid-burst is deferred until the burst's last bit
        dc = done_cnt;
        fork
            send(1'b0, 64'h33, 6, 1'b1, o);
            begin
                repeat (3) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        check("defer_no_early_done", done_cnt, dc);
        wait_done("defer_done_seen");
        check("defer_byte", log_data[log_data.size()-1], 8'hCC);
        check("defer_done_once", done_cnt, dc + 1);

        // Reset while DRAIN waits on acks: request drops at once, no done
        wr_ack = 1'b0;
        send(1'b1, 64'hBEEF, 16, 1'b1, o);
        pulse_flush();
        repeat (4) tick();
        check("drain_busy", busy, 1);
        check("drain_wr_req", wr_req, 1);
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rst_drops_wr_req", wr_req, 0);
        tick();
        rst = 1'b0;
        wr_ack = 1'b1;
        repeat (6) tick();
        check("rst_no_done", done_cnt, dc);
        check("rst_busy_low", busy, 0);
        check("rst_total_zero", total_bits, 0);
        check("rst_wr_req_low", wr_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
